// File: rtl/mxint8_pkg.sv
// Shared definitions for the MXINT8 block-sum slice.
//   - Format widths and block size of the MXINT8 / E8M0 / FP32 formats.
//   - SCALE_NAN: the E8M0 encoding that means "NaN scale".
//   - ctrl_state_t: sequencer states of mxint8_block_sum_ctrl.
//   - cnt_width(): counter width for a modulus n; always at least 1 bit.
package mxint8_pkg;

    localparam int unsigned MXINT8_ELEMENT_WIDTH = 8;
    localparam int unsigned SCALE_WIDTH          = 8;
    localparam int unsigned BLOCK_SIZE           = 32;
    localparam int unsigned FLOAT32_WIDTH        = 32;
    localparam logic [7:0]  SCALE_NAN            = 8'hFF;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_EVAL,
        ST_CAPT
    } ctrl_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mxint8_elem_bank.sv
// Element register file for one MX block.
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset; clears every element to 0
//   i_wr_en      write one beat
//   i_wr_beat    beat index; elements beat*LANES .. beat*LANES+LANES-1 are written
//   i_wr_lanes   LANES elements, lane 0 at the LSBs
//   o_rd_bank    whole block, element 0 at the LSBs
module mxint8_elem_bank #(
    parameter int unsigned BLOCK_SIZE = 32,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ELEM_W     = 8,
    parameter int unsigned BEAT_W     = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_en,
    input  logic [BEAT_W-1:0]            i_wr_beat,
    input  logic [LANES*ELEM_W-1:0]      i_wr_lanes,
    output logic [BLOCK_SIZE*ELEM_W-1:0] o_rd_bank
);

    localparam int unsigned BEATS  = BLOCK_SIZE / LANES;
    localparam int unsigned BEAT_B = LANES * ELEM_W;

    logic [BLOCK_SIZE*ELEM_W-1:0] bank_q;

    // One constant-indexed slice per beat keeps the write decode simple.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bank_q <= '0;
        end else if (i_wr_en) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (i_wr_beat == BEAT_W'(b)) begin
                    bank_q[b*BEAT_B +: BEAT_B] <= i_wr_lanes;
                end
            end
        end
    end

    assign o_rd_bank = bank_q;

endmodule

// File: rtl/mxint8_block_sum_ctrl.sv
// Sequencer for the combinational MXINT8 block-sum datapath.
// Collects a block from a LANES-wide valid/ready stream, holds scale and
// elements stable for the datapath, waits DP_LAT cycles, then captures the
// FP32 result and overflow flag into a one-entry output slot.
//   i_clk / i_rst_n              clock, asynchronous active-low reset
//   i_in_valid / o_in_ready      input beat handshake
//   i_in_scale                   block scale, taken on beat 0 only
//   i_in_elems                   LANES elements of the current beat
//   o_dp_scale / o_dp_elems      registered operands to the datapath
//   i_dp_float32 / i_dp_ovf      datapath result
//   o_out_valid / i_out_ready    result slot handshake
//   o_out_float32 / o_out_ovf    captured result of the block in the slot
//   o_ovf_sticky / i_clr_sticky  OR of captured overflows, synchronous clear
//   o_busy                       a block is in flight (not LOAD at beat 0)
module mxint8_block_sum_ctrl #(
    parameter int unsigned BLOCK_SIZE = 32,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ELEM_W     = mxint8_pkg::MXINT8_ELEMENT_WIDTH,
    parameter int unsigned SCALE_W    = mxint8_pkg::SCALE_WIDTH,
    parameter int unsigned DP_LAT     = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_in_valid,
    output logic                                 o_in_ready,
    input  logic [SCALE_W-1:0]                   i_in_scale,
    input  logic [LANES*ELEM_W-1:0]              i_in_elems,
    output logic [SCALE_W-1:0]                   o_dp_scale,
    output logic [BLOCK_SIZE*ELEM_W-1:0]         o_dp_elems,
    input  logic [mxint8_pkg::FLOAT32_WIDTH-1:0] i_dp_float32,
    input  logic                                 i_dp_ovf,
    output logic                                 o_out_valid,
    input  logic                                 i_out_ready,
    output logic [mxint8_pkg::FLOAT32_WIDTH-1:0] o_out_float32,
    output logic                                 o_out_ovf,
    output logic                                 o_ovf_sticky,
    input  logic                                 i_clr_sticky,
    output logic                                 o_busy
);

    import mxint8_pkg::*;

    localparam int unsigned BEATS  = BLOCK_SIZE / LANES;
    localparam int unsigned BEAT_W = cnt_width(BEATS);
    localparam int unsigned SET_W  = cnt_width(DP_LAT);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(DP_LAT - 1);

    ctrl_state_t                  state_q, state_d;
    logic [BEAT_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [SET_W-1:0]             settle_q, settle_d;
    logic                         run_q;
    logic [SCALE_W-1:0]           scale_q;
    logic                         out_valid_q;
    logic [FLOAT32_WIDTH-1:0]     out_float_q;
    logic                         out_ovf_q;
    logic                         sticky_q;
    logic                         beat_fire;
    logic                         capture;

    // run_q keeps ready low while reset is asserted and raises it on the
    // first clock after release, even though the FSM already sits in LOAD.
    assign o_in_ready = (state_q == ST_LOAD) && run_q;
    assign beat_fire  = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_LOAD;
            beat_cnt_q <= '0;
            settle_q   <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            settle_q   <= settle_d;
            run_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        settle_d   = settle_q;
        capture    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (beat_fire) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        settle_d   = '0;
                        state_d    = ST_EVAL;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            ST_EVAL: begin
                if (settle_q == LAST_SETTLE) begin
                    state_d = ST_CAPT;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_CAPT: begin
                // A slot being drained this cycle counts as free.
                if (!out_valid_q || i_out_ready) begin
                    capture = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scale_q <= '0;
        end else if (beat_fire && (beat_cnt_q == '0)) begin
            scale_q <= i_in_scale;
        end
    end

    mxint8_elem_bank #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .LANES      (LANES),
        .ELEM_W     (ELEM_W),
        .BEAT_W     (BEAT_W)
    ) u_bank (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (beat_fire),
        .i_wr_beat  (beat_cnt_q),
        .i_wr_lanes (i_in_elems),
        .o_rd_bank  (o_dp_elems)
    );

    // Capture has priority over the pop: the slot stays full with new data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q <= 1'b0;
            out_float_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            out_float_q <= i_dp_float32;
            out_ovf_q   <= i_dp_ovf;
        end else if (out_valid_q && i_out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Setting beats clearing when both happen in one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sticky_q <= 1'b0;
        end else if (capture && i_dp_ovf) begin
            sticky_q <= 1'b1;
        end else if (i_clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign o_dp_scale    = scale_q;
    assign o_out_valid   = out_valid_q;
    assign o_out_float32 = out_float_q;
    assign o_out_ovf     = out_ovf_q;
    assign o_ovf_sticky  = sticky_q;
    assign o_busy        = !((state_q == ST_LOAD) && (beat_cnt_q == '0));

endmodule

// File: tb/tb_mxint8_block_sum_ctrl.sv
module tb_mxint8_block_sum_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    // DP_LAT = 1 instance
    logic         in_valid, in_ready, out_ready, clr, out_valid, out_ovf, sticky, busy;
    logic [7:0]   in_scale, dp_scale;
    logic [31:0]  in_elems, dp_f, out_f;
    logic [255:0] dp_elems;
    logic         dp_ovf;
    // DP_LAT = 3 instance
    logic         in_valid3, in_ready3, out_ready3, out_valid3, out_ovf3, sticky3, busy3;
    logic [7:0]   in_scale3, dp_scale3;
    logic [31:0]  in_elems3, dp_f3, out_f3;
    logic [255:0] dp_elems3;
    logic         dp_ovf3;

    int checks   = 0;
    int failures = 0;

    // Datapath reference: sum of signed elements times 2^(scale-127) as FP32.
    // Overflow is modelled as scale >= 200; NaN scale yields a quiet NaN.
    function automatic logic [32:0] dp_model(input logic [7:0] s, input logic [255:0] e);
        int sum, m, p;
        logic [31:0] f;
        sum = 0;
        for (int i = 0; i < 32; i++) sum += $signed(e[i*8 +: 8]);
        if (s == 8'hFF) return {1'b0, 32'h7FC0_0000};
        if (sum == 0) begin
            f = '0;
        end else begin
            m = (sum < 0) ? -sum : sum;
            p = 0;
            for (int k = 0; k < 16; k++) if (((m >> k) & 1) != 0) p = k;
            f = {sum < 0, 8'(p + int'(s)), 23'((m << (23 - p)) & 32'h007F_FFFF)};
        end
        return {s >= 8'd200, f};
    endfunction

    assign {dp_ovf, dp_f}   = dp_model(dp_scale, dp_elems);
    assign {dp_ovf3, dp_f3} = dp_model(dp_scale3, dp_elems3);

    mxint8_block_sum_ctrl #(.BLOCK_SIZE(32), .LANES(4), .ELEM_W(8), .SCALE_W(8), .DP_LAT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_scale(in_scale), .i_in_elems(in_elems), .o_dp_scale(dp_scale), .o_dp_elems(dp_elems),
        .i_dp_float32(dp_f), .i_dp_ovf(dp_ovf), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_float32(out_f), .o_out_ovf(out_ovf), .o_ovf_sticky(sticky), .i_clr_sticky(clr),
        .o_busy(busy));

    mxint8_block_sum_ctrl #(.BLOCK_SIZE(32), .LANES(4), .ELEM_W(8), .SCALE_W(8), .DP_LAT(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid3), .o_in_ready(in_ready3),
        .i_in_scale(in_scale3), .i_in_elems(in_elems3), .o_dp_scale(dp_scale3), .o_dp_elems(dp_elems3),
        .i_dp_float32(dp_f3), .i_dp_ovf(dp_ovf3), .o_out_valid(out_valid3), .i_out_ready(out_ready3),
        .o_out_float32(out_f3), .o_out_ovf(out_ovf3), .o_ovf_sticky(sticky3), .i_clr_sticky(1'b0),
        .o_busy(busy3));

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard state
    typedef struct { logic [31:0] f; logic ovf; } res_t;
    res_t         exp_q[$];
    logic [255:0] cur_blk, last_blk;
    logic [7:0]   cur_scale, last_scale;
    int           pops = 0;

    // Compare process: runs after the drivers have settled each negedge.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_valid_unexpected actual=1 required=0");
                end else begin
                    chk("out_float32", out_f, exp_q[0].f);
                    chk("out_ovf", out_ovf, exp_q[0].ovf);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
            if (!in_ready && busy) begin
                chk("dp_elems_held", dp_elems, last_blk);
                chk("dp_scale_held", dp_scale, last_scale);
            end
        end
    end

    function automatic logic [255:0] rnd_blk();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Sends nb beats of blk; with gap set, idles randomly and drives garbage
    // (valid toggling) whenever the DUT is not ready. Returns at the negedge
    // after the last accepted beat, with in_valid low.
    task automatic send_block(input logic [7:0] sc, input logic [255:0] blk, input int nb, input bit gap);
        logic [32:0] r;
        int tries;
        for (int b = 0; b < nb; b++) begin
            if (gap) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_elems = $urandom;
                    in_scale = 8'($urandom);
                end
            end
            @(negedge clk);
            tries = 0;
            while (!in_ready && tries < 200) begin
                in_valid = gap ? 1'($urandom) : 1'b0;
                in_elems = $urandom;
                in_scale = 8'($urandom);
                @(negedge clk);
                tries++;
            end
            if (tries >= 200) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout actual=0 required=1");
            end
            in_valid = 1'b1;
            in_elems = blk[b*32 +: 32];
            in_scale = (b == 0) ? sc : 8'($urandom);
            @(posedge clk);
            if (b == 0) cur_scale = sc;
            cur_blk[b*32 +: 32] = blk[b*32 +: 32];
            if (b == 7) begin
                r = dp_model(cur_scale, cur_blk);
                exp_q.push_back('{f: r[31:0], ovf: r[32]});
                last_blk   = cur_blk;
                last_scale = cur_scale;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_f"}, out_f, 0);
        chk({tag, "_out_ovf"}, out_ovf, 0);
        chk({tag, "_sticky"}, sticky, 0);
        chk({tag, "_dp_scale"}, dp_scale, 0);
        chk({tag, "_dp_elems"}, dp_elems, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] ones, blk_a, blk_b, blk3, tmp;
        logic [32:0]  ra, rb, rm;
        int k, pops0;

        rst_n = 1'b0; in_valid = 1'b0; in_scale = '0; in_elems = '0; out_ready = 1'b1; clr = 1'b0;
        in_valid3 = 1'b0; in_scale3 = '0; in_elems3 = '0; out_ready3 = 1'b1;
        cur_blk = '0; last_blk = '0; cur_scale = '0; last_scale = '0;
        for (int i = 0; i < 32; i++) ones[i*8 +: 8] = 8'h01;

        // Model pins
        rm = dp_model(8'd127, ones);
        chk("model_ones", rm, {1'b0, 32'h4200_0000});
        for (int i = 0; i < 32; i++) blk3[i*8 +: 8] = 8'(i - 16);
        rm = dp_model(8'd127, blk3);
        chk("model_neg16", rm, {1'b0, 32'hC180_0000});

        // Reset state
        #1;
        chk_all_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_at_release", in_ready, 0);
        @(negedge clk);
        chk("ready_after_release", in_ready, 1);

        // Single block, latency 3 after the last beat
        send_block(8'd127, ones, 8, 1'b0);
        k = 1;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency_dp1", k, 3);
        chk("single_float", out_f, 32'h4200_0000);
        chk("single_elems", dp_elems, ones);
        drain();

        // Backpressure: block B completes but cannot be captured
        out_ready = 1'b0;
        blk_a = rnd_blk();
        blk_b = rnd_blk();
        ra = dp_model(8'd130, blk_a);
        rb = dp_model(8'd120, blk_b);
        send_block(8'd130, blk_a, 8, 1'b0);
        send_block(8'd120, blk_b, 8, 1'b0);
        repeat (4) begin
            @(negedge clk);
            in_valid = !in_ready;
            in_elems = $urandom;
            in_scale = 8'($urandom);
        end
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_busy", busy, 1);
        chk("bp_slot_a", out_f, ra[31:0]);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_valid_kept", out_valid, 1);
        chk("bp_slot_b", out_f, rb[31:0]);
        @(negedge clk);
        #1;
        chk("bp_valid_clear", out_valid, 0);

        // Gapped input with garbage, including a NaN-scale block
        send_block(8'd125, rnd_blk(), 8, 1'b1);
        send_block(8'hFF, rnd_blk(), 8, 1'b1);
        send_block(8'd131, rnd_blk(), 8, 1'b1);
        drain();

        // Overflow on the middle block only, then sticky handling
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        send_block(8'd130, rnd_blk(), 8, 1'b0);
        for (int i = 0; i < 32; i++) tmp[i*8 +: 8] = 8'($urandom_range(1, 20));
        send_block(8'd200, tmp, 8, 1'b0);
        send_block(8'd125, rnd_blk(), 8, 1'b0);
        drain();
        chk("sticky_set", sticky, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("sticky_cleared", sticky, 0);
        send_block(8'd210, tmp, 8, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr_vs_ovf_capture_valid", out_valid, 1);
        chk("clr_vs_ovf_capture_sticky", sticky, 1);
        drain();

        // Reset mid-load
        send_block(8'd127, rnd_blk(), 5, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pops0 = pops;
        send_block(8'd128, rnd_blk(), 8, 1'b0);
        drain();
        repeat (5) @(negedge clk);
        chk("midrst_one_result", pops - pops0, 1);
        chk("midrst_idle", out_valid, 0);

        // DP_LAT = 3 instance: latency and operand stability through EVAL
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            k = 0;
            while (!in_ready3 && k < 50) begin
                @(negedge clk);
                k++;
            end
            in_valid3 = 1'b1;
            in_elems3 = blk3[b*32 +: 32];
            in_scale3 = (b == 0) ? 8'd127 : 8'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid3 = 1'b0;
        k = 1;
        while (!out_valid3 && k < 20) begin
            #2;
            chk("dp3_elems_stable", dp_elems3, blk3);
            chk("dp3_scale_stable", dp_scale3, 8'd127);
            @(negedge clk);
            k++;
        end
        chk("latency_dp3", k, 5);
        chk("dp3_float", out_f3, 32'hC180_0000);
        chk("dp3_ovf", out_ovf3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
